calc_cmd_sequencer: RTL and testbench
=====================================

// Module: calc_cmd_sequencer
// PURPOSE
//  Upstream feeder for the stack calculator. Buffers 20-bit command words {cmd[3:0], payload[15:0]}
//  from a host valid/ready interface in a FIFO. Releases a program to the calculator's data port only
//  once it is complete (its done word has been buffered), one word per cycle, gap-free.
//  Holds off the next program until the calculator asserts finished.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of 2, >=4
//  CNT_W  8   width of prog_count
// PORTS
//  ck          in   1      clock; all state updates on posedge
//  rst_l       in   1      asynchronous, active-low reset
//  in_valid    in   1      host word valid
//  in_word     in   20     host word {cmd, payload}; cmd codes: start=4'h1, enter=4'h2, arithOp=4'h4, done=4'h8
//  in_ready    out  1      FIFO can accept; = !full (combinational)
//  data        out  20     registered word to calculator; 20'h0 = idle
//  finished    in   1      calculator has completed the current program
//  busy        out  1      state != IDLE (combinational from state)
//  prog_count  out  CNT_W  programs fully streamed (done word popped); wraps
//  frame_err   out  1      one-cycle registered pulse on a framing violation
// BEHAVIOUR
//  Reset (async, rst_l=0)
//   - FIFO empty; done_cnt=0; state=IDLE; data=20'h0; prog_count=0; frame_err=0.
//   - Takes effect mid-program too: buffered words are discarded.
//  FIFO
//   - Push when in_valid && in_ready. Pop only as described below.
//   - Simultaneous push and pop is legal: occupancy unchanged; a push while full cannot occur.
//   - done_cnt = number of done words in the FIFO. It counts +1 on push of done and -1 on pop of done;
//     when both happen in the same cycle it is unchanged.
//  launch = (done_cnt != 0) || full
//   - The full case covers a program longer than DEPTH: it streams anyway and relies on refill.
//  FSM, one edge each
//   IDLE:
//    - data<=0.
//    - If launch && !empty: pop head, data<=head.
//    - frame_err<=1 if head.cmd != start.
//    - state<=WAIT_FIN if head.cmd==done, else STREAM.
//   STREAM:
//    - If !empty: pop head, data<=head.
//    - frame_err<=1 if head.cmd==start, or head.cmd is not one of the four codes.
//    - If head.cmd==done: prog_count++, state<=WAIT_FIN.
//    - If empty (underrun): data<=0, frame_err<=1, stay STREAM.
//   WAIT_FIN:
//    - data<=0.
//    - When finished==1: state<=IDLE. The next launch is possible on the following edge.
//  General
//   - A single-word done program popped from IDLE also increments prog_count.
//   - finished is ignored in IDLE and STREAM.
//   - Erroneous words are still forwarded unchanged; the calculator reports protocolError itself.
//   - Latency: a complete program already in the FIFO drives its first word on data one edge after
//     launch is seen in IDLE. Subsequent words follow on consecutive edges.
//   - frame_err is cleared to 0 on every edge where no violation occurs.
// TESTING
//  1. Push start/1, enter/2, enter/3, arithOp/0x20, arithOp/0x1, done
//     -> data shows those 6 words on 6 consecutive edges, then 0.
//     -> prog_count=1; busy stays 1 until finished, then 0; frame_err never 1.
//  2. Push start/1, enter/2 only -> data stays 0 and busy=0 for 10 cycles.
//     Then push done -> the three words stream back-to-back.
//  3. Push DEPTH words with no done -> in_ready=0 at full; launch occurs.
//     When the FIFO drains: data=0 and frame_err pulses once per underrun cycle.
//  4. Program enter/5, done -> frame_err=1 on the edge enter/5 is driven; both words still forwarded.
//  5. Two complete programs buffered -> second start word is not driven until one edge after finished=1.
//     -> prog_count goes 1 then 2.
//  6. Assert rst_l=0 mid-STREAM (async, between edges)
//     -> data=0, busy=0, in_ready=1, prog_count=0 immediately; no residual words after release.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// Buffers host command words and releases whole programs to the stack calculator, one word per edge.
// Data is registered (1 edge after launch); host backpressure is in_ready = !full.
module calc_cmd_sequencer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             ck,
    input  logic             rst_l,
    input  logic             in_valid,
    input  logic [19:0]      in_word,
    output logic             in_ready,
    output logic [19:0]      data,
    input  logic             finished,
    output logic             busy,
    output logic [CNT_W-1:0] prog_count,
    output logic             frame_err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] CMD_START = 4'h1;
    localparam logic [3:0] CMD_ENTER = 4'h2;
    localparam logic [3:0] CMD_ARITH = 4'h4;
    localparam logic [3:0] CMD_DONE  = 4'h8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [19:0]      mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      done_cnt_q, done_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [19:0]      data_q, data_d;
    logic [CNT_W-1:0] prog_count_q, prog_count_d;
    logic             frame_err_q, frame_err_d;

    logic             empty, full, launch, push, pop;
    logic             push_done, pop_done;
    logic [19:0]      head;
    logic [3:0]       head_cmd;
    logic             head_legal;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_cmd = head[19:16];
    assign head_legal = (head_cmd == CMD_START) || (head_cmd == CMD_ENTER) ||
                        (head_cmd == CMD_ARITH) || (head_cmd == CMD_DONE);

    // A full FIFO launches anyway so programs longer than DEPTH still flow.
    assign launch    = (done_cnt_q != '0) || full;
    assign push_done = push && (in_word[19:16] == CMD_DONE);
    assign pop_done  = pop && (head_cmd == CMD_DONE);

    always_comb begin
        state_d      = state_q;
        data_d       = 20'h0;
        frame_err_d  = 1'b0;
        prog_count_d = prog_count_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch && !empty) begin
                    pop         = 1'b1;
                    data_d      = head;
                    frame_err_d = (head_cmd != CMD_START);
                    if (head_cmd == CMD_DONE) begin
                        state_d      = S_WAIT;
                        prog_count_d = prog_count_q + CNT_W'(1);
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (!empty) begin
                    pop         = 1'b1;
                    data_d      = head;
                    frame_err_d = (head_cmd == CMD_START) || !head_legal;
                    if (head_cmd == CMD_DONE) begin
                        state_d      = S_WAIT;
                        prog_count_d = prog_count_q + CNT_W'(1);
                    end
                end else begin
                    // Underrun: idle word to the calculator and flag the gap.
                    frame_err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (finished) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        done_cnt_d = done_cnt_q;
        if (push_done && !pop_done)      done_cnt_d = done_cnt_q + (AW+1)'(1);
        else if (pop_done && !push_done) done_cnt_d = done_cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge ck) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_word;
    end

    always_ff @(posedge ck or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            done_cnt_q   <= '0;
            state_q      <= S_IDLE;
            data_q       <= 20'h0;
            prog_count_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            done_cnt_q   <= done_cnt_d;
            state_q      <= state_d;
            data_q       <= data_d;
            prog_count_q <= prog_count_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign in_ready   = !full;
    assign data       = data_q;
    assign busy       = (state_q != S_IDLE);
    assign prog_count = prog_count_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: queue-based program model checked every cycle, plus directed literal checks.
module tb_calc_cmd_sequencer;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;

    logic             ck = 1'b0;
    logic             rst_l;
    logic             in_valid;
    logic [19:0]      in_word;
    logic             in_ready;
    logic [19:0]      data;
    logic             finished;
    logic             busy;
    logic [CNT_W-1:0] prog_count;
    logic             frame_err;

    int total = 0;
    int bad   = 0;

    calc_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .ck(ck), .rst_l(rst_l), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .data(data), .finished(finished), .busy(busy),
        .prog_count(prog_count), .frame_err(frame_err)
    );

    always #5 ck = ~ck;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: the buffer is a queue; mode 0 = waiting for a complete program,
    // 1 = forwarding a program, 2 = waiting for the calculator to finish.
    logic [19:0] mq[$];
    int          m_mode;
    logic [19:0] m_data;
    logic        m_ferr;
    logic [7:0]  m_pc;
    logic        m_has_done;
    logic        m_push;
    logic [19:0] m_word;
    logic [19:0] m_w;

    always @(posedge ck or negedge rst_l) begin
        if (!rst_l) begin
            mq.delete();
            m_mode = 0;
            m_data = 20'h0;
            m_ferr = 1'b0;
            m_pc   = 8'h0;
        end else begin
            m_has_done = 1'b0;
            foreach (mq[i]) if (mq[i][19:16] == 4'h8) m_has_done = 1'b1;
            m_push = in_valid && (mq.size() < DEPTH);
            m_word = in_word;
            m_data = 20'h0;
            m_ferr = 1'b0;
            if (m_mode == 0) begin
                if ((m_has_done || mq.size() == DEPTH) && mq.size() > 0) begin
                    m_w    = mq.pop_front();
                    m_data = m_w;
                    m_ferr = (m_w[19:16] != 4'h1);
                    if (m_w[19:16] == 4'h8) begin
                        m_pc   = m_pc + 8'd1;
                        m_mode = 2;
                    end else begin
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (mq.size() > 0) begin
                    m_w    = mq.pop_front();
                    m_data = m_w;
                    m_ferr = (m_w[19:16] == 4'h1) || !(m_w[19:16] inside {4'h1, 4'h2, 4'h4, 4'h8});
                    if (m_w[19:16] == 4'h8) begin
                        m_pc   = m_pc + 8'd1;
                        m_mode = 2;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
            end else begin
                if (finished) m_mode = 0;
            end
            if (m_push) mq.push_back(m_word);
        end
    end

    always @(negedge ck) begin
        if (rst_l === 1'b1) begin
            chk("model_data", data, m_data);
            chk("model_frame_err", frame_err, m_ferr);
            chk("model_prog_count", prog_count, m_pc);
            chk("model_busy", busy, m_mode != 0);
            chk("model_in_ready", in_ready, mq.size() < DEPTH);
        end
    end

    task automatic push(input logic [19:0] w);
        int n;
        @(negedge ck);
        in_valid = 1'b1;
        in_word  = w;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge ck);
            n++;
        end
        if (!in_ready) chk("push_timeout", in_ready, 1);
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        in_word  = 20'h0;
    endtask

    task automatic wait_data(input logic [19:0] w, input string nm);
        int n;
        n = 0;
        @(negedge ck);
        while (data !== w && n < 60) begin
            @(negedge ck);
            n++;
        end
        chk(nm, data, w);
    endtask

    task automatic next_data(input logic [19:0] w, input string nm);
        @(negedge ck);
        chk(nm, data, w);
    endtask

    task automatic fin();
        @(negedge ck);
        finished = 1'b1;
        @(negedge ck);
        finished = 1'b0;
        chk("busy_after_finished", busy, 0);
    endtask

    logic [19:0] p1 [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l    = 1'b0;
        in_valid = 1'b0;
        in_word  = 20'h0;
        finished = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        chk("rst_data", data, 20'h0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_prog_count", prog_count, 0);
        chk("rst_frame_err", frame_err, 0);
        @(negedge ck);
        #2 rst_l = 1'b1;

        // 1: basic six-word program
        p1[0] = 20'h10001; p1[1] = 20'h20002; p1[2] = 20'h20003;
        p1[3] = 20'h40020; p1[4] = 20'h40001; p1[5] = 20'h80000;
        for (int i = 0; i < 6; i++) push(p1[i]);
        wait_data(20'h10001, "t1_w0");
        for (int i = 1; i < 6; i++) next_data(p1[i], "t1_word");
        next_data(20'h0, "t1_idle_after");
        chk("t1_prog_count", prog_count, 1);
        chk("t1_busy_held", busy, 1);
        repeat (3) @(negedge ck);
        chk("t1_busy_still", busy, 1);
        fin();

        // 2: incomplete program is held back
        push(20'h10001);
        push(20'h20002);
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            chk("t2_hold_data", data, 20'h0);
            chk("t2_hold_busy", busy, 0);
        end
        push(20'h80000);
        wait_data(20'h10001, "t2_w0");
        next_data(20'h20002, "t2_w1");
        next_data(20'h80000, "t2_w2");
        chk("t2_prog_count", prog_count, 2);
        fin();

        // 3: overlong program launches on full, then underruns
        push(20'h10100);
        for (int k = 1; k < DEPTH; k++) push({4'h2, 16'(k)});
        chk("t3_full_in_ready", in_ready, 0);
        wait_data(20'h10100, "t3_w0");
        for (int k = 1; k < DEPTH; k++) next_data({4'h2, 16'(k)}, "t3_enter");
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            chk("t3_underrun_data", data, 20'h0);
            chk("t3_underrun_ferr", frame_err, 1);
        end
        push(20'h80000);
        wait_data(20'h80000, "t3_done");
        chk("t3_done_ferr", frame_err, 0);
        chk("t3_prog_count", prog_count, 3);
        fin();

        // 4: missing start word
        push(20'h20005);
        push(20'h80000);
        wait_data(20'h20005, "t4_w0");
        chk("t4_ferr_on_enter", frame_err, 1);
        next_data(20'h80000, "t4_w1");
        chk("t4_ferr_clear", frame_err, 0);
        chk("t4_prog_count", prog_count, 4);
        fin();

        // 5: second program waits for finished
        push(20'h10007);
        push(20'h80000);
        push(20'h10008);
        push(20'h20009);
        push(20'h80000);
        for (int i = 0; i < 5; i++) begin
            @(negedge ck);
            chk("t5_hold_data", data, 20'h0);
            chk("t5_hold_busy", busy, 1);
        end
        chk("t5_prog_count_a", prog_count, 5);
        @(negedge ck);
        finished = 1'b1;
        @(negedge ck);
        finished = 1'b0;
        chk("t5_gap_data", data, 20'h0);
        chk("t5_gap_busy", busy, 0);
        next_data(20'h10008, "t5_w0");
        next_data(20'h20009, "t5_w1");
        next_data(20'h80000, "t5_w2");
        chk("t5_prog_count_b", prog_count, 6);
        fin();

        // 6: async reset mid-stream
        push(20'h10001);
        push(20'h20002);
        push(20'h20003);
        push(20'h80000);
        wait_data(20'h10001, "t6_w0");
        @(posedge ck);
        #3 rst_l = 1'b0;
        #1;
        chk("t6_rst_data", data, 20'h0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_prog_count", prog_count, 0);
        @(posedge ck);
        @(negedge ck);
        #2 rst_l = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            chk("t6_post_data", data, 20'h0);
            chk("t6_post_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
